// File: rtl/regfile_wb_arbiter.sv
// Write-port controller for the 32x32 register file: post-reset zero-fill, then
// WB-first arbitration between write-back and mul/div with an MD starvation guard.
module regfile_wb_arbiter #(
   parameter int unsigned NUM_REGS     = 32,
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [4:0]  wb_reg,
   input  logic [31:0] wb_data,
   output logic        wb_ready,
   input  logic        md_valid,
   input  logic [4:0]  md_reg,
   input  logic [31:0] md_data,
   output logic        md_ready,
   output logic        RegWrite,
   output logic [4:0]  WriteReg,
   output logic [31:0] WriteData,
   output logic        init_done
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic {INIT, RUN} state_t;

   state_t              state_q, state_d;
   logic [REG_W-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                reg_write_d;
   logic [REG_W-1:0]    write_reg_d;
   logic [DATA_W-1:0]   write_data_d;
   logic                init_done_d;
   logic                force_md;

   // State and registered register-file outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= INIT;
         idx_q     <= '0;
         cnt_q     <= '0;
         RegWrite  <= 1'b0;
         WriteReg  <= '0;
         WriteData <= '0;
         init_done <= 1'b0;
      end else begin
         state_q   <= state_d;
         idx_q     <= idx_d;
         cnt_q     <= cnt_d;
         RegWrite  <= reg_write_d;
         WriteReg  <= write_reg_d;
         WriteData <= write_data_d;
         init_done <= init_done_d;
      end
   end

   // Zero-fill sequencing, grant, write selection and starvation counter
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      reg_write_d  = 1'b0;
      write_reg_d  = WriteReg;
      write_data_d = WriteData;
      init_done_d  = init_done;
      wb_ready     = 1'b0;
      md_ready     = 1'b0;
      force_md     = 1'b0;

      case (state_q)
         INIT: begin
            reg_write_d  = 1'b1;
            write_reg_d  = idx_q;
            write_data_d = '0;
            idx_d        = idx_q + REG_W'(1);
            if (idx_q == REG_W'(NUM_REGS - 1)) begin
               state_d     = RUN;
               init_done_d = 1'b1;
            end
         end
         RUN: begin
            force_md = md_valid && (cnt_q == CNT_W'(STARVE_LIMIT));
            if (force_md)      md_ready = 1'b1;
            else if (wb_valid) wb_ready = 1'b1;
            else               md_ready = md_valid;

            // Writes to r0 complete the handshake but never reach the file
            if (wb_valid && wb_ready) begin
               if (wb_reg != '0) begin
                  reg_write_d  = 1'b1;
                  write_reg_d  = wb_reg;
                  write_data_d = wb_data;
               end
            end else if (md_valid && md_ready) begin
               if (md_reg != '0) begin
                  reg_write_d  = 1'b1;
                  write_reg_d  = md_reg;
                  write_data_d = md_data;
               end
            end

            if (md_valid && !md_ready) begin
               if (cnt_q != CNT_W'(STARVE_LIMIT)) cnt_d = cnt_q + CNT_W'(1);
            end else begin
               cnt_d = '0;
            end
         end
         default: state_d = INIT;
      endcase
   end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed self-checking bench for regfile_wb_arbiter with default parameters.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        wb_valid, md_valid;
   logic [4:0]  wb_reg, md_reg;
   logic [31:0] wb_data, md_data;
   logic        wb_ready, md_ready;
   logic        RegWrite;
   logic [4:0]  WriteReg;
   logic [31:0] WriteData;
   logic        init_done;

   int n_checks = 0;
   int n_pass   = 0;

   regfile_wb_arbiter #(.NUM_REGS(32), .STARVE_LIMIT(4)) dut (
      .clk(clk), .rst(rst),
      .wb_valid(wb_valid), .wb_reg(wb_reg), .wb_data(wb_data), .wb_ready(wb_ready),
      .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
      .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
      .init_done(init_done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
   endtask

   // Advance to just after the next rising edge
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_rw"}, RegWrite, 0);
      check({tag, "_wr"}, WriteReg, 0);
      check({tag, "_wd"}, WriteData, 0);
      check({tag, "_done"}, init_done, 0);
   endtask

   initial begin
      rst = 1'b1;
      wb_valid = 0; md_valid = 0;
      wb_reg = 0; md_reg = 0; wb_data = 0; md_data = 0;
      #12;
      check_zero("reset");
      check("reset_wb_ready", wb_ready, 0);
      check("reset_md_ready", md_ready, 0);
      rst = 1'b0;

      // Zero-fill: valids held high must not be granted during INIT
      for (int i = 0; i < 32; i++) begin
         cyc();
         check("init_rw", RegWrite, 1);
         check("init_wr", WriteReg, 32'(i));
         check("init_wd", WriteData, 0);
         if (i < 31) begin
            wb_valid = 1; md_valid = 1;
            #1;
            check("init_wb_ready", wb_ready, 0);
            check("init_md_ready", md_ready, 0);
            check("init_done_low", init_done, 0);
         end else begin
            wb_valid = 0; md_valid = 0;
            check("init_done_high", init_done, 1);
         end
      end

      // Single WB write
      wb_valid = 1; wb_reg = 5; wb_data = 32'hDEADBEEF;
      #1;
      check("wb_only_ready", wb_ready, 1);
      check("wb_only_md_ready", md_ready, 0);
      cyc();
      wb_valid = 0;
      check("wb_only_rw", RegWrite, 1);
      check("wb_only_wr", WriteReg, 5);
      check("wb_only_wd", WriteData, 32'hDEADBEEF);
      cyc();
      check("idle_rw", RegWrite, 0);
      check("idle_wr_hold", WriteReg, 5);
      check("idle_wd_hold", WriteData, 32'hDEADBEEF);

      // Starvation guard: 4 WB grants, MD forced on the 5th cycle
      md_valid = 1; md_reg = 20; md_data = 32'h77;
      for (int k = 0; k < 5; k++) begin
         wb_valid = 1; wb_reg = 5'(10 + k); wb_data = 32'(k + 100);
         #1;
         check("starve_wb_ready", wb_ready, (k < 4) ? 1 : 0);
         check("starve_md_ready", md_ready, (k == 4) ? 1 : 0);
         cyc();
         if (k == 4) md_valid = 0;
         check("starve_wr", WriteReg, (k < 4) ? 32'(10 + k) : 32'd20);
         check("starve_wd", WriteData, (k < 4) ? 32'(k + 100) : 32'h77);
      end
      #1;
      check("resume_wb_ready", wb_ready, 1);
      cyc();
      wb_valid = 0;
      check("resume_wr", WriteReg, 14);
      check("resume_wd", WriteData, 104);

      // MD write to r0 is accepted but dropped
      md_valid = 1; md_reg = 0; md_data = 32'h1234;
      #1;
      check("r0_md_ready", md_ready, 1);
      cyc();
      md_valid = 0;
      check("r0_rw", RegWrite, 0);
      check("r0_wr_hold", WriteReg, 14);

      // Same destination from both: WB first, MD value lands last
      wb_valid = 1; wb_reg = 9; wb_data = 32'hAAAA;
      md_valid = 1; md_reg = 9; md_data = 32'h5555;
      #1;
      check("same_wb_ready", wb_ready, 1);
      check("same_md_ready", md_ready, 0);
      cyc();
      wb_valid = 0;
      check("same_first_rw", RegWrite, 1);
      check("same_first_wd", WriteData, 32'hAAAA);
      #1;
      check("same_md_ready2", md_ready, 1);
      cyc();
      md_valid = 0;
      check("same_second_rw", RegWrite, 1);
      check("same_second_wr", WriteReg, 9);
      check("same_second_wd", WriteData, 32'h5555);

      // Reset mid-INIT at idx 17
      #1;
      rst = 1; #2;
      check_zero("rst1");
      rst = 0;
      for (int i = 0; i < 18; i++) cyc();
      check("pre_rst2_wr", WriteReg, 17);
      #1;
      rst = 1; #2;
      check_zero("rst2");
      rst = 0;
      cyc();
      check("restart_rw", RegWrite, 1);
      check("restart_wr", WriteReg, 0);
      for (int i = 0; i < 31; i++) cyc();
      check("reinit_wr", WriteReg, 31);
      check("reinit_done", init_done, 1);

      // Reset during a granted WB transfer: write must not be issued
      wb_valid = 1; wb_reg = 3; wb_data = 32'hCAFE;
      #1;
      check("mid_run_wb_ready", wb_ready, 1);
      rst = 1; #1;
      check_zero("rst3");
      check("rst3_wb_ready", wb_ready, 0);
      wb_valid = 0;
      rst = 0;
      cyc();
      check("post_rst3_rw", RegWrite, 1);
      check("post_rst3_wr", WriteReg, 0);
      check("post_rst3_wd", WriteData, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-port controller for the 32x32 register file. It sequences a post-reset zero-fill of every register, then shares the single write port between two requesters: the pipeline write-back stage (WB) and the multi-cycle mul/div unit (MD). It uses valid/ready handshakes, WB-first priority and a starvation guard for MD. Its registered outputs drive the register file's RegWrite/WriteReg/WriteData inputs directly.

## Interface
- NUM_REGS, 32, number of registers zero-filled during init (2..32)
- STARVE_LIMIT, 4, consecutive stalled MD cycles before MD is forced through (1..15)
- clk  in  1  system clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- wb_valid  in  1  WB write request
- wb_reg  in  5  WB destination register
- wb_data  in  32  WB write data
- wb_ready  out  1  WB request accepted this cycle
- md_valid  in  1  MD write request
- md_reg  in  5  MD destination register
- md_data  in  32  MD write data
- md_ready  out  1  MD request accepted this cycle
- RegWrite  out  1  register-file write enable (registered)
- WriteReg  out  5  register-file write index (registered)
- WriteData  out  32  register-file write data (registered)
- init_done  out  1  high once zero-fill complete (registered)

## Operation
- Reset values: RegWrite=0, WriteReg=0, WriteData=0, init_done=0, init index=0, starve counter=0, state=INIT.
- States: INIT and RUN.
- INIT: each rising edge loads RegWrite=1, WriteReg=idx, WriteData=0, then idx++. On the edge that loads idx=NUM_REGS-1: state->RUN, init_done<=1. wb_ready=md_ready=0 throughout INIT.
- RUN, grant (combinational from state, valids and counter):
  - force = md_valid && (starve counter == STARVE_LIMIT).
  - If force: md_ready=1, wb_ready=0.
  - Else if wb_valid: wb_ready=1, md_ready=0.
  - Else md_ready=md_valid.
  - At most one ready is high per cycle.
- Transfer = valid && ready. On transfer, the next edge loads RegWrite=1 and WriteReg/WriteData from the winner. With no transfer, RegWrite<=0 and WriteReg/WriteData hold.
- Register 0: a transfer with reg==0 is accepted (ready high, the requester completes) but dropped. RegWrite<=0.
- Starve counter, RUN only:
  - Increments, saturating at STARVE_LIMIT, each cycle md_valid && !md_ready.
  - Clears on MD transfer or when md_valid=0.
- Requesters hold valid/reg/data stable until ready. Dropping valid without ready is allowed. No ordering between WB and MD is guaranteed.
- Same-register requests in the same cycle: only the granted one writes. The loser writes in a later cycle, and its value wins last.
- rst asserted at any time, including mid-INIT or mid-transfer: all state returns to reset values immediately and INIT restarts from idx 0. An in-flight request not yet registered is lost.

## Timing
- Zero-fill occupies NUM_REGS cycles. init_done rises on edge NUM_REGS after rst deassertion. The first RUN grant happens in the cycle after that edge.
- Request-to-write latency: 1 cycle. Transfer in cycle N gives RegWrite high during cycle N+1, and the register file commits on edge N+2.
- Throughput: one write per cycle.
- Worst-case MD wait under continuous WB traffic: STARVE_LIMIT cycles, with the grant in cycle STARVE_LIMIT+1 of the request.
- No combinational path from the valid/reg/data inputs to RegWrite/WriteReg/WriteData. Ready depends combinationally on the valids only.

## Test plan
- Reset release, no requests -> 32 consecutive cycles with RegWrite=1, WriteReg 0..31, WriteData=0. init_done=1 after edge 32. Both readies 0 during INIT.
- RUN, wb_valid only (reg 5, data 0xDEADBEEF) -> wb_ready=1 same cycle. Next cycle RegWrite=1, WriteReg=5, WriteData=0xDEADBEEF.
- wb_valid and md_valid held high together, STARVE_LIMIT=4 -> WB granted for 4 cycles, MD granted in cycle 5, then the counter clears and WB resumes.
- md_valid (reg 0, data 0x1234) alone -> md_ready=1, RegWrite stays 0.
- WB and MD both targeting reg 9 (0xAAAA, 0x5555) -> WB written first, MD one cycle later. Final value 0x5555.
- rst pulsed mid-INIT at idx=17, then mid-RUN during a granted transfer -> outputs return to 0 asynchronously, INIT restarts at WriteReg=0, and the pending write is not issued.
